// File: rtl/ex_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_ctrl
//  Description : Multi-cycle RV32M multiply/divide sequencer beside the EX
//                stage. It captures operands, stalls the pipeline, runs a
//                shift-add multiplier or restoring divider for ITER cycles,
//                applies sign fix-up and returns the result with a one-cycle
//                done pulse. Division by zero and signed overflow take a
//                one-cycle fast path.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_ctrl #(
  parameter int XLEN = 32,
  parameter int ITER = 32   // iteration count, must equal XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam int CW = $clog2(ITER + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [1:0]        state;
  logic [CW-1:0]     count;
  logic [2:0]        op;          // captured funct3
  logic [4:0]        rd_q;
  logic              neg_res;     // product / quotient needs negation
  logic              neg_rem;     // remainder takes the dividend's sign
  logic [2*XLEN-1:0] acc;         // mul: {high, multiplier}; div: low half = dividend/quotient
  logic [XLEN-1:0]   mcand;       // multiplicand magnitude or divisor magnitude
  logic [XLEN:0]     rem;         // partial remainder
  logic [XLEN-1:0]   result_q;

  // --------------------------------------------------------------------------
  // Issue-time decode
  // --------------------------------------------------------------------------
  logic            a_signed;
  logic            b_signed;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            is_div_in;
  logic            is_rem_in;
  logic            div_zero;
  logic            div_ovf;
  logic            fast_path;
  logic [XLEN-1:0] fast_result;
  logic            accept;

  // Operand signedness, magnitudes and fast-path detection for a new issue
  always_comb begin
    a_signed    = 1'b0;
    b_signed    = 1'b0;
    case (funct3_i)
      3'd0, 3'd1, 3'd4, 3'd6: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'd2:                   begin a_signed = 1'b1; b_signed = 1'b0; end
      default:                begin a_signed = 1'b0; b_signed = 1'b0; end
    endcase
    sign_a      = a_signed & rs1_i[XLEN-1];
    sign_b      = b_signed & rs2_i[XLEN-1];
    mag_a       = sign_a ? (~rs1_i + 1'b1) : rs1_i;
    mag_b       = sign_b ? (~rs2_i + 1'b1) : rs2_i;
    is_div_in   = funct3_i[2];
    is_rem_in   = funct3_i[2] & funct3_i[1];
    div_zero    = is_div_in && (rs2_i == '0);
    // Only DIV/REM (signed) can overflow: MIN / -1
    div_ovf     = is_div_in && !funct3_i[0] && (rs1_i == MIN_NEG) && (rs2_i == ALL_ONES);
    fast_path   = div_zero | div_ovf;
    fast_result = '0;
    if (div_zero) begin
      fast_result = is_rem_in ? rs1_i : ALL_ONES;
    end else if (div_ovf) begin
      fast_result = is_rem_in ? '0 : MIN_NEG;
    end
    accept      = start_i & ~flush_i;
  end

  // --------------------------------------------------------------------------
  // One iteration of the multiplier and of the divider
  // --------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN+1:0]   div_shift;
  logic [XLEN+1:0]   div_diff;
  logic              div_ge;
  logic [XLEN:0]     div_rem_next;
  logic [2*XLEN-1:0] div_acc_next;

  // Shift-add step and restoring-divide step, selected by the captured op
  always_comb begin
    // Multiply: add multiplicand to the high half when the multiplier LSB is
    // set, then shift the whole accumulator right; the carry enters the top.
    mul_sum      = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mcand : {XLEN{1'b0}})};
    mul_next     = {mul_sum, acc[XLEN-1:1]};
    // Divide: bring the next dividend bit into the partial remainder and
    // subtract the divisor when the difference stays non-negative.
    div_shift    = {rem, acc[XLEN-1]};
    div_diff     = div_shift - {2'b00, mcand};
    div_ge       = ~div_diff[XLEN+1];
    div_rem_next = div_ge ? div_diff[XLEN:0] : div_shift[XLEN:0];
    div_acc_next = {{XLEN{1'b0}}, acc[XLEN-2:0], div_ge};
  end

  // --------------------------------------------------------------------------
  // Sign fix-up and result selection
  // --------------------------------------------------------------------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_result;

  // Apply two's-complement correction and pick the architectural result
  always_comb begin
    prod_fix = neg_res ? (~acc + 1'b1) : acc;
    quo_fix  = neg_res ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    rem_fix  = neg_rem ? (~rem[XLEN-1:0] + 1'b1) : rem[XLEN-1:0];
    case (op)
      3'd0:             fix_result = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fix_result = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:       fix_result = quo_fix;
      default:          fix_result = rem_fix;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  // Control FSM plus datapath register updates
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      count    <= '0;
      op       <= '0;
      rd_q     <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      rem      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op      <= funct3_i;
            rd_q    <= rd_i;
            neg_res <= sign_a ^ sign_b;
            neg_rem <= sign_a;
            count   <= '0;
            rem     <= '0;
            mcand   <= mag_b;
            acc     <= {{XLEN{1'b0}}, mag_a};
            if (fast_path) begin
              result_q <= fast_result;
              state    <= S_DONE;
            end else begin
              state    <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush_i) begin
            state <= S_IDLE;
          end else begin
            count <= count + CW'(1);
            if (op[2]) begin
              acc <= div_acc_next;
              rem <= div_rem_next;
            end else begin
              acc <= mul_next;
            end
            if (count == CW'(ITER - 1)) begin
              state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (flush_i) begin
            state <= S_IDLE;
          end else begin
            result_q <= fix_result;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Stall/busy/done decode; a flush drops stall and suppresses done at once
  always_comb begin
    stall_o = 1'b0;
    case (state)
      S_IDLE:         stall_o = accept;
      S_CALC, S_FIX:  stall_o = ~flush_i;
      default:        stall_o = 1'b0;
    endcase
    busy_o   = (state != S_IDLE);
    done_o   = (state == S_DONE) & ~flush_i;
    result_o = result_q;
    rd_o     = rd_q;
  end

endmodule
`default_nettype wire

// File: doc/ex_muldiv_ctrl.md
Name: ex_muldiv_ctrl

Overview:
- Multi-cycle sequencer for RV32M multiply/divide operations issued from the EX stage.
- Captures operands when EX presents an M-extension instruction and holds the pipeline via stall until the result is ready.
- Runs an iterative shift-add multiplier or restoring divider for 32 iterations, applies sign fix-up, and returns the 32-bit result with a one-cycle done pulse.
- Sits beside the EX stage; its stall_o is ORed into the pipeline stall network.

Parameters:
- XLEN, 32, operand/result width.
- ITER, 32, number of CALC iterations; must equal XLEN.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start_i  input  1  M-extension instruction valid in EX; sampled only in IDLE
- funct3_i  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_i  input  XLEN  forwarded operand A
- rs2_i  input  XLEN  forwarded operand B
- rd_i  input  5  destination register
- flush_i  input  1  abort current operation (mispredict correction)
- stall_o  output  1  hold pipeline
- busy_o  output  1  state != IDLE
- done_o  output  1  result valid, one-cycle pulse
- result_o  output  XLEN  result, valid while done_o=1
- rd_o  output  5  captured rd, valid while done_o=1

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE. done_o=0, busy_o=0, result_o=0, rd_o=0, counter=0, all datapath registers 0. Reset mid-operation discards the operation with no done pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - stall_o = start_i & ~flush_i (combinational).
  - On start_i & ~flush_i, capture funct3, rd, operand signs and magnitudes:
    - MUL, MULH, DIV, REM: both operands signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - MULHU, DIVU, REMU: both unsigned.
  - Go to CALC with counter=0.
  - Fast path for division by zero (rs2=0): go directly to DONE. Quotient = 0xFFFFFFFF; remainder = rs1.
  - Fast path for signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): go directly to DONE. Quotient = 0x80000000; remainder = 0.
- CALC: one iteration per cycle; counter increments; stall_o=1. After iteration index ITER-1 completes, go to FIX.
  - Multiply: 64-bit accumulator; add multiplicand if LSB of multiplier is set; shift.
  - Divide: 33-bit partial remainder; shift in the next dividend bit; subtract the divisor if non-negative.
- FIX: stall_o=1.
  - Product is negated (two's complement, 64-bit) if the sign of A differs from the sign of B, for signed cases.
  - Quotient is negated if the signs differ. Remainder takes the dividend's sign.
  - Select result: MUL takes the low 32 bits; MULH/MULHSU/MULHU take the high 32 bits. Then go to DONE.
- DONE: done_o=1, stall_o=0, result_o and rd_o valid. Next edge goes to IDLE. start_i is ignored in DONE.
- Latency:
  - Normal path: start sampled in cycle 0; done_o high in cycle 34 (32 CALC + 1 FIX + DONE entry).
  - Fast path: done_o high in cycle 1.
- flush_i:
  - In any non-IDLE state, the next state is IDLE with no done pulse, and stall_o drops in the same cycle.
  - flush_i together with start_i in IDLE: the start is ignored.
- start_i while busy is ignored; no queuing.
- busy_o=0 only in IDLE. result_o holds its last value outside DONE.

Test Plan:
- MUL: rs1=7, rs2=0xFFFFFFFD (-3) -> done_o in cycle 34, result_o=0xFFFFFFEB; stall_o high cycles 0–33, low in cycle 34.
- MULH: rs1=0x80000000, rs2=0x80000000 -> result_o=0x40000000. MULHU with the same operands -> 0x40000000. MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV: rs1=-7 (0xFFFFFFF9), rs2=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Fast paths: DIVU rs2=0, rs1=5 -> done_o in cycle 1, result_o=0xFFFFFFFF. REM rs2=0, rs1=5 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, latency 1.
- Abort: flush_i asserted in cycle 10 of CALC -> IDLE next cycle, no done_o, stall_o=0. A new start in cycle 12 completes normally.
- Reset mid-CALC (rst=1 in cycle 20) -> done_o never pulses, result_o=0, busy_o=0. start_i held high during CALC is ignored and only one done_o pulse occurs.
